// File: rtl/cordic_byte_sequencer_pkg.sv
// Shared types and sizing constants for the CORDIC byte sequencer.
// Frame layout: 4 operand bytes in, 6 result bytes out.
package cordic_seq_pkg;

  typedef enum logic [1:0] {
    LOAD,
    START,
    WAIT,
    SEND
  } state_t;

  localparam int IN_BYTES    = 4;
  localparam int OUT_BYTES   = 6;
  localparam int DEF_TIMEOUT = 255;
  localparam int IN_IDX_W    = $clog2(IN_BYTES);
  localparam int OUT_IDX_W   = $clog2(OUT_BYTES);

endpackage

// File: rtl/cordic_byte_sequencer_if.sv
// Byte-serial host port: operand bytes in, result bytes out,
// each direction under its own valid/ready pair.
interface cordic_byte_sequencer_if;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready
  );

endinterface

// File: rtl/cordic_byte_sequencer.sv
// Packs host bytes into X/Y, runs the CORDIC core under a
// watchdog, then streams magnitude and phase back bytewise.
module cordic_byte_sequencer
  import cordic_seq_pkg::*;
#(
  parameter int XW      = 16,
  parameter int PW      = 32,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  cordic_byte_sequencer_if.slave host,
  output logic                   core_start,
  output logic [XW-1:0]          core_x,
  output logic [XW-1:0]          core_y,
  input  logic                   core_done,
  input  logic [XW-1:0]          core_mag,
  input  logic [PW-1:0]          core_phase,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int NI    = 2 * XW / 8;
  localparam int NO    = (XW + PW) / 8;
  localparam int NMAX  = (NO > NI) ? NO : NI;
  localparam int IDX_W = $clog2(NMAX);
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam int RW    = XW + PW;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WD_W-1:0]    wd_q;
  logic [2*XW-1:0]    opr_q;
  logic [RW-1:0]      res_q, res_d;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [7:0]         out_data_q;
  logic               core_start_q;
  logic               busy_q;
  logic               timeout_err_q;

  logic accept;
  logic got;
  logic expire;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    accept  = 1'b0;
    got     = 1'b0;
    expire  = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (host.in_valid && in_ready_q) begin
          accept = 1'b1;
          if (idx_q == IDX_W'(NI - 1)) begin
            idx_d   = '0;
            state_d = START;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        // done takes priority over a simultaneous watchdog expiry
        if (core_done) begin
          got     = 1'b1;
          idx_d   = '0;
          state_d = SEND;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          expire  = 1'b1;
          idx_d   = '0;
          state_d = LOAD;
        end
      end
      SEND: begin
        if (out_valid_q && host.out_ready) begin
          if (idx_q == IDX_W'(NO - 1)) begin
            idx_d   = '0;
            state_d = LOAD;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  assign res_d = got ? {core_phase, core_mag} : res_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= LOAD;
      idx_q         <= '0;
      wd_q          <= '0;
      opr_q         <= '0;
      res_q         <= '0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      core_start_q  <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      wd_q    <= (state_q == WAIT) ? wd_q + WD_W'(1) : '0;
      if (accept) begin
        opr_q[int'(idx_q)*8 +: 8] <= host.in_data;
      end
      if (accept && idx_q == '0) begin
        timeout_err_q <= 1'b0;
      end else if (expire) begin
        timeout_err_q <= 1'b1;
      end
      // outputs follow the next state so they are flops, not decodes
      in_ready_q   <= (state_d == LOAD);
      out_valid_q  <= (state_d == SEND);
      core_start_q <= (state_d == START);
      busy_q       <= (state_d != LOAD);
      out_data_q   <= (state_d == SEND) ? res_d[int'(idx_d)*8 +: 8] : 8'h00;
    end
  end

  assign host.in_ready  = in_ready_q;
  assign host.out_valid = out_valid_q;
  assign host.out_data  = out_data_q;
  assign core_start     = core_start_q;
  assign core_x         = opr_q[XW-1:0];
  assign core_y         = opr_q[2*XW-1:XW];
  assign busy           = busy_q;
  assign timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_cordic_byte_sequencer.sv
// Bench for cordic_byte_sequencer with a behavioural CORDIC
// core model and a byte scoreboard for the result stream.
module tb_cordic_byte_sequencer;
  import cordic_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cordic_byte_sequencer_if host ();

  logic        core_start;
  logic        core_done = 1'b0;
  logic [15:0] core_x, core_y;
  logic [15:0] core_mag = '0;
  logic [31:0] core_phase = '0;
  logic        busy, timeout_err;

  cordic_byte_sequencer #(
    .XW(16), .PW(32), .TIMEOUT(255)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .host       (host),
    .core_start (core_start),
    .core_x     (core_x),
    .core_y     (core_y),
    .core_done  (core_done),
    .core_mag   (core_mag),
    .core_phase (core_phase),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  int          lat = 16;
  bit          suppress = 1'b0;
  logic [15:0] m_mag = '0;
  logic [31:0] m_phase = '0;
  int          cnt = 0;
  int          starts = 0;
  logic [15:0] cap_x = '0, cap_y = '0;

  // core model: done pulses lat cycles after the start pulse
  always @(negedge clk) begin
    core_done  = 1'b0;
    core_mag   = 16'($urandom);
    core_phase = $urandom;
    if (rst) begin
      cnt = 0;
    end else if (core_start) begin
      starts++;
      cap_x = core_x;
      cap_y = core_y;
      cnt = lat;
    end else if (cnt > 0) begin
      cnt--;
      if (cnt == 0 && !suppress) begin
        core_done  = 1'b1;
        core_mag   = m_mag;
        core_phase = m_phase;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic push_exp(input logic [15:0] mg, input logic [31:0] ph);
    exp_q.push_back(mg[7:0]);
    exp_q.push_back(mg[15:8]);
    exp_q.push_back(ph[7:0]);
    exp_q.push_back(ph[15:8]);
    exp_q.push_back(ph[23:16]);
    exp_q.push_back(ph[31:24]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int g = 0;
    while (!host.in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!host.in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL in_ready_wait: got 0 want 1");
    end
    host.in_data  = b;
    host.in_valid = 1'b1;
    @(negedge clk);
    host.in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] x, input logic [15:0] y,
                            input int gap);
    send_byte(x[7:0]);
    repeat (gap) @(negedge clk);
    send_byte(x[15:8]);
    repeat (gap) @(negedge clk);
    send_byte(y[7:0]);
    repeat (gap) @(negedge clk);
    send_byte(y[15:8]);
  endtask

  task automatic collect(input int nb, input int stall_at,
                         input int stall_len);
    int got = 0;
    int stalled = 0;
    int cyc = 0;
    logic [7:0] e;
    while (got < nb && cyc < 2000) begin
      if (got == stall_at && stalled > 0 && !host.out_valid) begin
        n_cmp++;
        n_bad++;
        $display("FAIL valid_drop: out_valid got 0 want 1");
      end
      host.out_ready = !(host.out_valid && got == stall_at &&
                         stalled < stall_len);
      if (host.out_valid) begin
        e = (exp_q.size() > 0) ? exp_q[0] : 8'hxx;
        n_cmp++;
        if (host.out_data !== e) begin
          n_bad++;
          $display("FAIL out_byte%0d: got %h want %h", got,
                   host.out_data, e);
        end
        if (host.out_ready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          got++;
        end else begin
          stalled++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    host.out_ready = 1'b1;
    n_cmp++;
    if (got != nb) begin
      n_bad++;
      $display("FAIL collect_count: got %0d want %0d", got, nb);
    end
  endtask

  task automatic check_idle(input string tag);
    n_cmp++;
    if (host.out_valid !== 1'b0 || host.in_ready !== 1'b1 ||
        busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_idle: valid/ready/busy got %b%b%b want 010",
               tag, host.out_valid, host.in_ready, busy);
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if (host.in_ready !== 1'b1 || host.out_valid !== 1'b0 ||
        core_start !== 1'b0 || busy !== 1'b0 ||
        timeout_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_flags: rdy/vld/st/busy/to got %b%b%b%b%b want 10000",
               host.in_ready, host.out_valid, core_start, busy, timeout_err);
    end
    n_cmp++;
    if (host.out_data !== 8'h00 || core_x !== 16'h0 ||
        core_y !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_regs: data/x/y got %h/%h/%h want 00/0000/0000",
               host.out_data, core_x, core_y);
    end
  endtask

  task automatic test_basic();
    int s0 = starts;
    m_mag   = 16'h1234;
    m_phase = 32'hDEADBEEF;
    lat     = 16;
    push_exp(m_mag, m_phase);
    send_frame(16'h3524, 16'h5E81, 0);
    n_cmp++;
    if (core_start !== 1'b1 || host.in_ready !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_start: start/rdy/busy got %b%b%b want 101",
               core_start, host.in_ready, busy);
    end
    n_cmp++;
    if (core_x !== 16'h3524 || core_y !== 16'h5E81) begin
      n_bad++;
      $display("FAIL basic_operands: got %h/%h want 3524/5e81",
               core_x, core_y);
    end
    @(negedge clk);
    n_cmp++;
    if (core_start !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_pulse: core_start got 1 want 0");
    end
    collect(6, -1, 0);
    check_idle("basic");
    n_cmp++;
    if (starts - s0 != 1) begin
      n_bad++;
      $display("FAIL basic_starts: got %0d want 1", starts - s0);
    end
  endtask

  task automatic test_backpressure();
    m_mag   = 16'h1234;
    m_phase = 32'hDEADBEEF;
    push_exp(m_mag, m_phase);
    send_frame(16'h3524, 16'h5E81, 0);
    collect(6, 2, 5);
    check_idle("bp");
  endtask

  task automatic test_gaps();
    m_mag   = 16'hA5C3;
    m_phase = 32'h0BADF00D;
    push_exp(m_mag, m_phase);
    send_frame(16'h3524, 16'h5E81, 3);
    host.in_data  = 8'hFF;
    host.in_valid = 1'b1;
    n_cmp++;
    if (host.in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL gaps_ready: in_ready got 1 want 0");
    end
    collect(6, -1, 0);
    host.in_valid = 1'b0;
    n_cmp++;
    if (cap_x !== 16'h3524 || cap_y !== 16'h5E81) begin
      n_bad++;
      $display("FAIL gaps_operands: got %h/%h want 3524/5e81",
               cap_x, cap_y);
    end
    n_cmp++;
    if (core_x !== 16'h3524 || core_y !== 16'h5E81) begin
      n_bad++;
      $display("FAIL gaps_hold: got %h/%h want 3524/5e81", core_x, core_y);
    end
    check_idle("gaps");
  endtask

  task automatic test_timeout();
    int  cyc = 0;
    bit  saw = 1'b0;
    suppress = 1'b1;
    send_frame(16'h1111, 16'h2222, 0);
    while (!timeout_err && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (host.out_valid) saw = 1'b1;
    end
    n_cmp++;
    if (cyc != 256) begin
      n_bad++;
      $display("FAIL timeout_cycles: got %0d want 256", cyc);
    end
    n_cmp++;
    if (saw) begin
      n_bad++;
      $display("FAIL timeout_output: out_valid got 1 want 0");
    end
    check_idle("timeout");
    suppress = 1'b0;
    m_mag    = 16'h0F0E;
    m_phase  = 32'h76543210;
    push_exp(m_mag, m_phase);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (timeout_err !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_sticky: got 0 want 1");
    end
    send_byte(8'h44);
    n_cmp++;
    if (timeout_err !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_clear: got 1 want 0");
    end
    send_byte(8'h33);
    send_byte(8'h22);
    send_byte(8'h11);
    collect(6, -1, 0);
    check_idle("after_to");
  endtask

  task automatic test_reset_mid();
    m_mag   = 16'hCAFE;
    m_phase = 32'h13579BDF;
    push_exp(m_mag, m_phase);
    send_frame(16'h7788, 16'h99AA, 0);
    collect(3, -1, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    check_idle("rst_mid");
    test_reset();
    m_mag   = 16'hBEEF;
    m_phase = 32'h02468ACE;
    push_exp(m_mag, m_phase);
    send_frame(16'h0102, 16'h0304, 0);
    collect(6, -1, 0);
    check_idle("rst_fresh");
  endtask

  task automatic test_back_to_back();
    int s0 = starts;
    lat     = 5;
    m_mag   = 16'h5A5A;
    m_phase = 32'hFEDCBA98;
    push_exp(m_mag, m_phase);
    send_frame(16'h1357, 16'h2468, 0);
    collect(6, -1, 0);
    n_cmp++;
    if (cap_x !== 16'h1357 || cap_y !== 16'h2468) begin
      n_bad++;
      $display("FAIL b2b_op1: got %h/%h want 1357/2468", cap_x, cap_y);
    end
    m_mag   = 16'h0001;
    m_phase = 32'h80000000;
    push_exp(m_mag, m_phase);
    send_frame(16'hFFFF, 16'h8000, 0);
    collect(6, -1, 0);
    n_cmp++;
    if (cap_x !== 16'hFFFF || cap_y !== 16'h8000) begin
      n_bad++;
      $display("FAIL b2b_op2: got %h/%h want ffff/8000", cap_x, cap_y);
    end
    n_cmp++;
    if (starts - s0 != 2) begin
      n_bad++;
      $display("FAIL b2b_starts: got %0d want 2", starts - s0);
    end
    check_idle("b2b");
  endtask

  initial begin
    host.in_data   = 8'h00;
    host.in_valid  = 1'b0;
    host.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_gaps();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
